// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS pipeline
package mips_pkg;
    localparam int IW = 32;
    localparam logic [IW-1:0] MIPS_NOP = '0;
    localparam logic [31:0] PC_RESET = '0;
endpackage

// File: rtl/mips_fetch_stage_if.sv
// mips_fetch_stage_if: program load, hazard/redirect controls and IF/ID outputs of the fetch stage
interface mips_fetch_stage_if #(parameter int AW = 6);
    logic          LoadEn;
    logic [AW-1:0] LoadAddr;
    logic [31:0]   LoadData;
    logic          Stall;
    logic          Redirect;
    logic [31:0]   RedirectPC;
    logic [31:0]   Opcode;
    logic [31:0]   PCPlus4;
    logic          IFValid;
    logic [31:0]   PC;
    modport master (
        output LoadEn, LoadAddr, LoadData, Stall, Redirect, RedirectPC,
        input  Opcode, PCPlus4, IFValid, PC
    );
    modport slave (
        input  LoadEn, LoadAddr, LoadData, Stall, Redirect, RedirectPC,
        output Opcode, PCPlus4, IFValid, PC
    );
endinterface

// File: rtl/mips_fetch_stage_instr_mem.sv
// instr_mem: word-addressed instruction store, sync write, async read, NOP beyond DEPTH
module instr_mem import mips_pkg::*; #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [29:0]   raddr,
    output logic [IW-1:0] rdata
);
    logic [IW-1:0] mem [DEPTH];
    always_ff @(posedge Clk)
        if (we) mem[waddr] <= wdata;
    // raddr is the word address; any set bit above the index means past the end
    assign rdata = (|raddr[29:AW]) ? MIPS_NOP : mem[raddr[AW-1:0]];
endmodule

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: PC register, next-PC selection and IF/ID pipeline register
module mips_fetch_stage import mips_pkg::*; #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input logic Clk,
    input logic Re,
    mips_fetch_stage_if.slave bus
);
    logic [IW-1:0] fetched;
    logic [31:0]   pc_plus4;
    logic          hold;
    assign pc_plus4 = bus.PC + 32'd4;
    assign hold     = bus.LoadEn;
    instr_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .Clk   (Clk),
        .we    (bus.LoadEn & ~Re),
        .waddr (bus.LoadAddr),
        .wdata (bus.LoadData),
        .raddr (bus.PC[31:2]),
        .rdata (fetched)
    );
    // a load freezes the pipeline, and redirect wins over stall
    always_ff @(posedge Clk) begin
        if (Re) begin
            bus.PC      <= PC_RESET;
            bus.Opcode  <= MIPS_NOP;
            bus.PCPlus4 <= '0;
            bus.IFValid <= 1'b0;
        end else if (!hold && bus.Redirect) begin
            bus.PC      <= bus.RedirectPC & ~32'h3;
            bus.Opcode  <= MIPS_NOP;
            bus.PCPlus4 <= '0;
            bus.IFValid <= 1'b0;
        end else if (!hold && !bus.Stall) begin
            bus.PC      <= pc_plus4;
            bus.Opcode  <= fetched;
            bus.PCPlus4 <= pc_plus4;
            bus.IFValid <= 1'b1;
        end
    end
endmodule

// File: doc/mips_fetch_stage.md
# mips_fetch_stage

Instruction-fetch stage for the MIPS pipeline: holds the program counter, reads a word-addressed instruction memory and registers the fetched word into the IF/ID pipeline register. Its `Opcode` output drives the decode/execute datapath directly, replacing today's bench-driven `Opcode`. It accepts stall and redirect (branch/jump) requests from downstream and has a load port so benches can preload programs.

## Interface
Parameters:
- DEPTH, 64: instruction memory size in 32-bit words (power of two, ≥ 4)
- AW, 6: word-index width, equal to log2(DEPTH)

Ports (one clock; reset is synchronous and active-high):
- Clk  input  1  rising-edge clock
- Re  input  1  synchronous active-high reset
- LoadEn  input  1  write LoadData into memory at LoadAddr this edge
- LoadAddr  input  AW  word index for program load
- LoadData  input  32  instruction word to load
- Stall  input  1  hold PC and IF/ID (hazard unit)
- Redirect  input  1  branch/jump taken: change PC and flush IF/ID
- RedirectPC  input  32  byte target address for Redirect
- Opcode  output  32  IF/ID instruction register
- PCPlus4  output  32  IF/ID PC+4 register
- IFValid  output  1  IF/ID holds a real fetched instruction
- PC  output  32  current fetch address

## Operation
- Memory index = PC[AW+1:2]. Fetch address PC ≥ DEPTH*4 returns NOP (32'h0); no wrap.
- Each edge, priority order:
  1. Re: PC←0, Opcode←0, PCPlus4←0, IFValid←0. Memory contents are not cleared.
  2. LoadEn: mem[LoadAddr]←LoadData; PC and IF/ID hold (load acts as a stall).
  3. Redirect: PC←{RedirectPC[31:2],2'b00}; Opcode←NOP, IFValid←0, PCPlus4←0. Redirect overrides Stall.
  4. Stall: PC, Opcode, PCPlus4, IFValid hold.
  5. Otherwise: Opcode←fetch(PC), PCPlus4←PC+4, IFValid←1, PC←PC+4.
- PC+4 is 32-bit modulo; overflow wraps silently.
- Misaligned RedirectPC low bits are dropped, never faulted.
- LoadEn and Redirect in the same cycle: the write happens, Redirect is ignored (load has priority; do not mix in normal use).

## Timing
- Fetch latency: 1 cycle from PC value to Opcode.
- First instruction: Re sampled high at edge k, low at edge k+1 → after k+1 Opcode=mem[0], PCPlus4=4, PC=4.
- Redirect sampled at edge n → after n bubble (IFValid=0); after n+1 Opcode=mem[target], PCPlus4=target+4.
- Stall for m cycles delays the sequence by exactly m cycles; no instruction is skipped or duplicated in IFValid-qualified output.
- Memory write visible to a fetch on the edge after the write edge.
- All outputs are registered; no combinational path from Stall/Redirect to outputs.

## Structure
- Shared package `mips_pkg`: `MIPS_NOP` (32'h0), `PC_RESET` (32'h0), instruction width 32.
- One sub-module, `instr_mem`: DEPTH×32 array, synchronous write port, combinational read port, range check returning NOP.
- Top holds the PC register, next-PC mux and IF/ID register.

## Test plan
- Reset/sequence: load mem[0..2]=8C0A0008, 8C0C0010, 014C7020; pulse Re → Opcode 8C0A0008/8C0C0010/014C7020 on consecutive cycles, PCPlus4 4/8/12, IFValid=1.
- Stall: assert Stall for 2 cycles after first fetch → Opcode held at 8C0A0008 and PC held at 4 for 2 cycles, then sequence resumes without loss.
- Redirect: Redirect=1, RedirectPC=32'h0000000A at PC=8 → next Opcode=0, IFValid=0; then Opcode=mem[2], PCPlus4=12.
- Redirect+Stall same cycle → redirect taken, PC=target.
- Out of range: run PC to DEPTH*4 → Opcode=0, IFValid=1, PC keeps incrementing.
- Reset mid-run: assert Re with PC=20 → next edge PC=0, IFValid=0; memory contents still present, and refetch returns mem[0].
